axi_burst_master: RTL
=====================

// Module: axi_burst_master
// PURPOSE
//  Cache-side AXI master: moves one cache line between cache and the external AXI memory slave.
//  A line fill is one INCR read burst; a writeback is one INCR write burst plus its B response.
//  Sits between the cache controller FSM and the memory-side AXI slave.
//  Converts one start pulse into a full burst handshake; returns a one-cycle done pulse.
// PARAMETERS
//  AXI_ADDR_WIDTH  64   address width
//  AXI_DATA_WIDTH  32   beat width
//  LINE_WIDTH      512  cache line width; BEATS = LINE_WIDTH/AXI_DATA_WIDTH (16), must be integer <= 256
// PORTS
//  clk               in   1     clock
//  arstn             in   1     reset: asynchronous, active-low
//  i_start_read      in   1     1-cycle request: fetch line at i_addr
//  i_start_write     in   1     1-cycle request: write i_line_wr to i_addr
//  i_addr            in   AW    line base address; aligned to LINE_WIDTH/8
//  i_line_wr         in   LINE  line to write; sampled with start
//  o_line_rd         out  LINE  assembled read line; beat k lands in [k*DW +: DW]
//  o_busy            out  1     high in every non-IDLE state
//  o_done            out  1     1-cycle pulse when a transaction completes
//  o_error           out  1     sticky error; cleared by the next accepted start
//  AR_VALID/AW_VALID out  1     address valid
//  AR_READY/AW_READY in   1     address ready
//  AR_ADDR/AW_ADDR   out  AW    latched i_addr
//  AR_LEN/AW_LEN     out  8     BEATS-1
//  AR_SIZE/AW_SIZE   out  3     log2(DW/8), i.e. 3'd2
//  AR_BURST/AW_BURST out  2     2'b01 (INCR)
//  AR_PROT/AW_PROT   out  3     3'b000
//  R_DATA, R_RESP    in   DW,2  read beat data and response
//  R_LAST, R_VALID   in   1     read last beat; read valid
//  R_READY           out  1     read ready
//  W_DATA            out  DW    beat w_cnt of the latched line
//  W_STRB            out  DW/8  all ones
//  W_LAST, W_VALID   out  1     write last beat; write valid
//  W_READY           in   1     write ready
//  B_RESP, B_VALID   in   2,1   write response and response valid
//  B_READY           out  1     response ready
// BEHAVIOUR
//  States: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP.
//  - IDLE: i_start_read -> RADDR; else i_start_write -> WADDR.
//  - Both starts high together: the read wins; the write is dropped.
//  - An accepted start latches i_addr (and i_line_wr for a write), clears the beat counter and o_error.
//  - Starts arriving outside IDLE are ignored.
//  - RADDR: AR_VALID=1 until AR_VALID&AR_READY, then RDATA.
//  - RDATA: R_READY=1. Each R handshake stores R_DATA at beat r_cnt, then r_cnt++.
//  - RDATA exit: IDLE on the handshake where R_LAST=1 or r_cnt==BEATS-1, whichever comes first.
//  - WADDR: AW_VALID=1 until AW handshake, then WDATA.
//  - WDATA: W_VALID=1 and W_LAST=(w_cnt==BEATS-1). w_cnt++ per handshake; the handshake with W_LAST -> WRESP.
//  - WRESP: B_READY=1; B handshake -> IDLE.
//  AXI rules: a VALID stays high with stable payload until its handshake. A VALID never depends on a READY.
//  Latency: AR_VALID/AW_VALID assert the cycle after the start.
//  o_done: asserted the cycle after the final R beat or the B handshake.
//  o_line_rd: complete and stable when o_done is high; held until the next read's first beat.
//  o_error is set by any of:
//   - R_RESP != 2'b00 on any beat;
//   - R_LAST on a beat other than BEATS-1, or missing on beat BEATS-1;
//   - B_RESP != 2'b00.
//  An error does not abort the burst.
//  Counters are $clog2(BEATS)+1 bits wide and never wrap inside a burst.
//  Reset values (immediate on arstn low, also mid-burst):
//   - state IDLE; every VALID/READY output 0;
//   - o_busy, o_done, o_error 0; o_line_rd 0; counters 0.
//  The burst in flight is abandoned on reset.
// TESTING
//  - Read 0x1000, slave returns beats 0..15 = 0xA000_0000+k, OKAY, R_LAST on beat 15
//    -> AR_LEN=15, AR_SIZE=2, AR_BURST=1; o_line_rd[31:0]=0xA0000000, [511:480]=0xA000000F; one o_done; o_error=0.
//  - Write 0x2040, line word k = k
//    -> 16 W beats, W_DATA=k in order, W_LAST only on beat 15, W_STRB=4'hF.
//    -> o_done the cycle after the B handshake (B_RESP=0).
//  - Backpressure: hold AR_READY=0 for 5 cycles; toggle R_VALID/W_READY randomly
//    -> VALIDs and payload held; no beat lost or duplicated.
//  - R_LAST on beat 9 -> burst ends at 10 beats; o_done=1; o_error=1.
//  - B_RESP=2'b10 -> o_error=1, cleared by the next start.
//  - i_start_read and i_start_write in the same cycle -> read only.
//  - arstn low mid-WDATA (beat 7) -> all VALIDs 0 immediately; state IDLE; a new read then completes cleanly.

Source files
------------

// File: rtl/axi_burst_master.sv
// Cache-side AXI4 burst master. It moves one cache line per request: a line fill is one INCR
// read burst, and a writeback is one INCR write burst followed by its B response.
module axi_burst_master #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int LINE_WIDTH     = 512
) (
  input  logic                          clk,
  input  logic                          arstn,
  input  logic                          i_start_read,
  input  logic                          i_start_write,
  input  logic [AXI_ADDR_WIDTH-1:0]     i_addr,
  input  logic [LINE_WIDTH-1:0]         i_line_wr,
  output logic [LINE_WIDTH-1:0]         o_line_rd,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_error,
  output logic                          AR_VALID,
  input  logic                          AR_READY,
  output logic [AXI_ADDR_WIDTH-1:0]     AR_ADDR,
  output logic [7:0]                    AR_LEN,
  output logic [2:0]                    AR_SIZE,
  output logic [1:0]                    AR_BURST,
  output logic [2:0]                    AR_PROT,
  input  logic [AXI_DATA_WIDTH-1:0]     R_DATA,
  input  logic [1:0]                    R_RESP,
  input  logic                          R_LAST,
  input  logic                          R_VALID,
  output logic                          R_READY,
  output logic                          AW_VALID,
  input  logic                          AW_READY,
  output logic [AXI_ADDR_WIDTH-1:0]     AW_ADDR,
  output logic [7:0]                    AW_LEN,
  output logic [2:0]                    AW_SIZE,
  output logic [1:0]                    AW_BURST,
  output logic [2:0]                    AW_PROT,
  output logic [AXI_DATA_WIDTH-1:0]     W_DATA,
  output logic [AXI_DATA_WIDTH/8-1:0]   W_STRB,
  output logic                          W_LAST,
  output logic                          W_VALID,
  input  logic                          W_READY,
  input  logic [1:0]                    B_RESP,
  input  logic                          B_VALID,
  output logic                          B_READY
);

  localparam int DW    = AXI_DATA_WIDTH;
  localparam int BEATS = LINE_WIDTH / AXI_DATA_WIDTH;
  localparam int IW    = $clog2(BEATS);
  localparam int CW    = $clog2(BEATS) + 1;

  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic [7:0]    BURST_LEN = 8'(BEATS - 1);
  localparam logic [2:0]    BEAT_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RADDR = 3'd1,
    S_RDATA = 3'd2,
    S_WADDR = 3'd3,
    S_WDATA = 3'd4,
    S_WRESP = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [CW-1:0]           r_cnt;
  logic                    r_done;
  logic                    r_error;
  logic [DW-1:0]           r_rbeat [BEATS];
  logic [DW-1:0]           r_wbeat [BEATS];

  logic w_ar_valid;
  logic w_aw_valid;
  logic w_r_ready;
  logic w_w_valid;
  logic w_w_last;
  logic w_b_ready;
  logic w_busy;
  logic w_start_rd;
  logic w_start_wr;
  logic w_r_hs;
  logic w_r_final;
  logic w_r_err;
  logic w_w_hs;
  logic w_b_hs;

  // Handshake qualifiers; a read request wins when both starts arrive together.
  always_comb begin
    w_start_rd = (r_state == S_IDLE) && i_start_read;
    w_start_wr = (r_state == S_IDLE) && !i_start_read && i_start_write;
    w_r_hs     = w_r_ready && R_VALID;
    w_r_final  = w_r_hs && (R_LAST || (r_cnt == LAST_BEAT));
    w_r_err    = (R_RESP != 2'b00) || (R_LAST != (r_cnt == LAST_BEAT));
    w_w_hs     = w_w_valid && W_READY;
    w_b_hs     = w_b_ready && B_VALID;
  end

  // State register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start_read) begin
          w_next_state = S_RADDR;
        end else if (i_start_write) begin
          w_next_state = S_WADDR;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RADDR: begin
        if (AR_READY) begin
          w_next_state = S_RDATA;
        end else begin
          w_next_state = S_RADDR;
        end
      end
      S_RDATA: begin
        if (w_r_final) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_RDATA;
        end
      end
      S_WADDR: begin
        if (AW_READY) begin
          w_next_state = S_WDATA;
        end else begin
          w_next_state = S_WADDR;
        end
      end
      S_WDATA: begin
        if (w_w_hs && w_w_last) begin
          w_next_state = S_WRESP;
        end else begin
          w_next_state = S_WDATA;
        end
      end
      S_WRESP: begin
        if (B_VALID) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_WRESP;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode. VALID/READY depend only on the registered state, never on a READY input.
  always_comb begin
    w_ar_valid = 1'b0;
    w_aw_valid = 1'b0;
    w_r_ready  = 1'b0;
    w_w_valid  = 1'b0;
    w_w_last   = 1'b0;
    w_b_ready  = 1'b0;
    w_busy     = 1'b1;
    case (r_state)
      S_IDLE:  w_busy     = 1'b0;
      S_RADDR: w_ar_valid = 1'b1;
      S_RDATA: w_r_ready  = 1'b1;
      S_WADDR: w_aw_valid = 1'b1;
      S_WDATA: begin
        w_w_valid = 1'b1;
        w_w_last  = (r_cnt == LAST_BEAT);
      end
      S_WRESP: w_b_ready  = 1'b1;
      default: w_busy     = 1'b0;
    endcase
  end

  // Datapath: address latch, beat counter, line buffers, done pulse and sticky error.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_addr  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      for (int i = 0; i < BEATS; i++) begin
        r_rbeat[i] <= '0;
        r_wbeat[i] <= '0;
      end
    end else begin
      r_done <= w_r_final || w_b_hs;
      if (w_start_rd || w_start_wr) begin
        r_addr  <= i_addr;
        r_cnt   <= '0;
        r_error <= 1'b0;
      end else begin
        if (w_r_hs) begin
          r_rbeat[r_cnt[IW-1:0]] <= R_DATA;
          r_cnt                  <= r_cnt + CW'(1);
          if (w_r_err) begin
            r_error <= 1'b1;
          end
        end
        if (w_w_hs) begin
          r_cnt <= r_cnt + CW'(1);
        end
        if (w_b_hs && (B_RESP != 2'b00)) begin
          r_error <= 1'b1;
        end
      end
      if (w_start_wr) begin
        for (int i = 0; i < BEATS; i++) begin
          r_wbeat[i] <= i_line_wr[i*DW +: DW];
        end
      end
    end
  end

  for (genvar g = 0; g < BEATS; g++) begin : g_line_rd
    assign o_line_rd[g*DW +: DW] = r_rbeat[g];
  end

  assign o_busy   = w_busy;
  assign o_done   = r_done;
  assign o_error  = r_error;

  assign AR_VALID = w_ar_valid;
  assign AR_ADDR  = r_addr;
  assign AR_LEN   = BURST_LEN;
  assign AR_SIZE  = BEAT_SIZE;
  assign AR_BURST = 2'b01;
  assign AR_PROT  = 3'b000;
  assign R_READY  = w_r_ready;

  assign AW_VALID = w_aw_valid;
  assign AW_ADDR  = r_addr;
  assign AW_LEN   = BURST_LEN;
  assign AW_SIZE  = BEAT_SIZE;
  assign AW_BURST = 2'b01;
  assign AW_PROT  = 3'b000;
  assign W_DATA   = r_wbeat[r_cnt[IW-1:0]];
  assign W_STRB   = '1;
  assign W_LAST   = w_w_last;
  assign W_VALID  = w_w_valid;
  assign B_READY  = w_b_ready;

endmodule
